// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline-stage registers: FSM state encoding
// and the default field widths of a MEM/WB-style entry.
package pipe_pkg;

    // Fill level of a stage; the encoding equals the number of held entries.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    // Default widths: ALU address + memory data, MemToReg/RegWrite, register index.
    localparam int DEF_DATA_W  = 64;
    localparam int DEF_CTRL_W  = 2;
    localparam int DEF_RDEST_W = 5;

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline entry {data, ctrl, rdest}: load-enabled, with a synchronous
// clear of the control field so a squashed entry cannot write back.
module pipe_entry_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int CTRL_W  = DEF_CTRL_W,
    parameter int RDEST_W = DEF_RDEST_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               clear_ctrl,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [CTRL_W-1:0]  in_ctrl,
    input  logic [RDEST_W-1:0] in_rdest,
    output logic [DATA_W-1:0]  data,
    output logic [CTRL_W-1:0]  ctrl,
    output logic [RDEST_W-1:0] rdest
);

    // Capture on load; clear of ctrl wins over load, reset clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            data  <= '0;
            ctrl  <= '0;
            rdest <= '0;
        end else begin
            if (clear_ctrl) begin
                ctrl <= '0;
            end else if (load) begin
                ctrl <= in_ctrl;
            end
            if (load) begin
                data  <= in_data;
                rdest <= in_rdest;
            end
        end
    end

endmodule

// File: rtl/pipe_skid_stage.sv
// Parametrised pipeline-stage register with valid/ready handshake, a
// two-entry skid buffer (main drives the outputs, skid absorbs one extra
// entry during a stall) and a synchronous flush for branch/exception recovery.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int CTRL_W  = DEF_CTRL_W,
    parameter int RDEST_W = DEF_RDEST_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [CTRL_W-1:0]  in_ctrl,
    input  logic [RDEST_W-1:0] in_rdest,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [CTRL_W-1:0]  out_ctrl,
    output logic [RDEST_W-1:0] out_rdest,
    output logic [1:0]         occupancy
);

    logic [1:0]         state_reg;
    logic [1:0]         state_next;
    logic               in_fire;
    logic               out_fire;
    logic               main_load;
    logic               skid_load;
    logic [DATA_W-1:0]  main_src_data;
    logic [CTRL_W-1:0]  main_src_ctrl;
    logic [RDEST_W-1:0] main_src_rdest;
    logic [DATA_W-1:0]  main_data;
    logic [CTRL_W-1:0]  main_ctrl;
    logic [RDEST_W-1:0] main_rdest;
    logic [DATA_W-1:0]  skid_data;
    logic [CTRL_W-1:0]  skid_ctrl;
    logic [RDEST_W-1:0] skid_rdest;

    assign in_ready  = (state_reg != ST_FULL);
    assign out_valid = (state_reg != ST_EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    // Outputs come straight from main; a bubble never carries control bits.
    assign out_data  = main_data;
    assign out_rdest = main_rdest;
    assign out_ctrl  = out_valid ? main_ctrl : '0;

    // Occupancy decoded from the fill state.
    always_comb begin
        occupancy = 2'd0;
        case (state_reg)
            ST_ONE:  occupancy = 2'd1;
            ST_FULL: occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    // Main refills from skid when draining FULL, otherwise from the input port.
    assign main_src_data  = (state_reg == ST_FULL) ? skid_data  : in_data;
    assign main_src_ctrl  = (state_reg == ST_FULL) ? skid_ctrl  : in_ctrl;
    assign main_src_rdest = (state_reg == ST_FULL) ? skid_rdest : in_rdest;

    // Next-state and register-load decode; flush empties the stage and drops any capture.
    always_comb begin
        state_next = state_reg;
        main_load  = 1'b0;
        skid_load  = 1'b0;
        case (state_reg)
            ST_EMPTY: begin
                if (in_fire) begin
                    main_load  = 1'b1;
                    state_next = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_fire && out_fire) begin
                    main_load = 1'b1;
                end else if (in_fire) begin
                    skid_load  = 1'b1;
                    state_next = ST_FULL;
                end else if (out_fire) begin
                    state_next = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_fire) begin
                    main_load  = 1'b1;
                    state_next = ST_ONE;
                end
            end
            default: begin
                state_next = ST_EMPTY;
            end
        endcase
        if (flush) begin
            state_next = ST_EMPTY;
            main_load  = 1'b0;
            skid_load  = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    pipe_entry_reg #(
        .DATA_W  (DATA_W),
        .CTRL_W  (CTRL_W),
        .RDEST_W (RDEST_W)
    ) u_main (
        .clk        (clk),
        .rst        (rst),
        .load       (main_load),
        .clear_ctrl (flush),
        .in_data    (main_src_data),
        .in_ctrl    (main_src_ctrl),
        .in_rdest   (main_src_rdest),
        .data       (main_data),
        .ctrl       (main_ctrl),
        .rdest      (main_rdest)
    );

    pipe_entry_reg #(
        .DATA_W  (DATA_W),
        .CTRL_W  (CTRL_W),
        .RDEST_W (RDEST_W)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .load       (skid_load),
        .clear_ctrl (flush),
        .in_data    (in_data),
        .in_ctrl    (in_ctrl),
        .in_rdest   (in_rdest),
        .data       (skid_data),
        .ctrl       (skid_ctrl),
        .rdest      (skid_rdest)
    );

endmodule
